// File: rtl/persiana_multinivel_if.sv
// Panel/sensor/motor bundle for the multi-level blind controller.
// Latency: none, plain wires; the controller registers everything it drives.
// Backpressure: none, the controller samples every input on every clock.
// master: panel, sensors and motor driver side (drives requests, reads motor/status)
// slave : the controller (reads requests, drives motor/status)
interface persiana_multinivel_if #(
    parameter int NIVELES = 4
);
    localparam int IW = $clog2(NIVELES);

    logic [NIVELES-1:0] boton_nivel;  // manual request, one bit per position
    logic               automatico;   // 1: target comes from the light sensor
    logic [IW-1:0]      sensor;       // light-derived target index
    logic [NIVELES-1:0] fin_carrera;  // limit switches, bit i = blind at position i
    logic               subir;        // motor up (toward index 0)
    logic               bajar;        // motor down (toward NIVELES-1)
    logic [IW-1:0]      posicion;     // last confirmed position
    logic               pos_valida;   // posicion confirmed since reset
    logic               falla;        // sticky motion timeout

    modport master (
        output boton_nivel, automatico, sensor, fin_carrera,
        input  subir, bajar, posicion, pos_valida, falla
    );

    modport slave (
        input  boton_nivel, automatico, sensor, fin_carrera,
        output subir, bajar, posicion, pos_valida, falla
    );
endinterface

// File: rtl/persiana_multinivel.sv
// Multi-level blind controller: picks a target position, homes, moves, pauses between moves, faults on stall.
// Latency: decisions on edge N are visible after edge N; all outputs come from registers.
// Backpressure: none; inputs are sampled every cycle, the motor driver has no ready signal.
// Ports: Reloj (clock), reset (sync, active-high), persiana (slave side of persiana_multinivel_if:
//        boton_nivel/automatico/sensor/fin_carrera in, subir/bajar/posicion/pos_valida/falla out).
module persiana_multinivel #(
    parameter int NIVELES  = 4,
    parameter int TIMEOUT  = 1000,
    parameter int DEADTIME = 16
) (
    input  logic                  Reloj,
    input  logic                  reset,
    persiana_multinivel_if.slave  persiana
);
    localparam int IW   = $clog2(NIVELES);
    localparam int MAXC = (TIMEOUT > DEADTIME) ? TIMEOUT : DEADTIME;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [IW-1:0] ULTIMO = IW'(NIVELES - 1);

    typedef enum logic [2:0] {REPOSO, SUBIENDO, BAJANDO, PAUSA, FALLA} estado_t;

    estado_t         estado, siguiente;
    logic [IW-1:0]   objetivo, objetivo_sig;
    logic [IW-1:0]   posicion;
    logic            pos_valida;
    // Side of the blind relative to posicion when it is off every switch:
    // 1 = below (last seen moving down), 0 = above.
    logic            debajo;
    logic [CW-1:0]   contador;

    logic [IW-1:0]   fin_idx, boton_idx;
    logic            fin_hay, boton_hay, en_objetivo, en_posicion;
    logic            movimiento, pos_cambia, detras;

    // Lowest set index wins for both switches and buttons.
    always_comb begin
        fin_idx   = '0;
        boton_idx = '0;
        for (int i = NIVELES - 1; i >= 0; i--) begin
            if (persiana.fin_carrera[i]) fin_idx   = IW'(i);
            if (persiana.boton_nivel[i]) boton_idx = IW'(i);
        end
    end

    assign fin_hay     = |persiana.fin_carrera;
    assign boton_hay   = |persiana.boton_nivel;
    assign en_objetivo = |(persiana.fin_carrera & (NIVELES'(1) << objetivo));
    assign en_posicion = |(persiana.fin_carrera & (NIVELES'(1) << posicion));
    assign movimiento  = (estado == SUBIENDO) || (estado == BAJANDO);
    assign pos_cambia  = fin_hay && (fin_idx != posicion);

    // Target behind the direction of travel. An equal index counts as behind
    // when the blind already sits on the far side of that switch. Not used
    // while homing, where posicion means nothing yet.
    always_comb begin
        detras = 1'b0;
        if (pos_valida) begin
            if (estado == SUBIENDO)
                detras = (objetivo > posicion) || ((objetivo == posicion) && !debajo);
            else if (estado == BAJANDO)
                detras = (objetivo < posicion) || ((objetivo == posicion) && debajo);
        end
    end

    always_comb begin
        objetivo_sig = objetivo;
        if (persiana.automatico) begin
            if (int'(persiana.sensor) > NIVELES - 1) objetivo_sig = ULTIMO;
            else                                     objetivo_sig = persiana.sensor;
        end else if (boton_hay) begin
            objetivo_sig = boton_idx;
        end
    end

    always_comb begin
        siguiente = estado;
        case (estado)
            REPOSO: begin
                if (!pos_valida) begin
                    // A switch that is already high confirms position next edge.
                    if (!fin_hay) siguiente = SUBIENDO;
                end else if (objetivo < posicion) begin
                    siguiente = SUBIENDO;
                end else if (objetivo > posicion) begin
                    siguiente = BAJANDO;
                end else if (!en_posicion) begin
                    // Stopped off-switch after a reversal: go back to it.
                    siguiente = debajo ? SUBIENDO : BAJANDO;
                end
            end
            SUBIENDO, BAJANDO: begin
                if (en_objetivo || (!pos_valida && fin_hay) || detras)
                    siguiente = PAUSA;
                else if (contador == CW'(TIMEOUT))
                    siguiente = FALLA;
            end
            PAUSA: begin
                if (contador == CW'(DEADTIME - 1)) siguiente = REPOSO;
            end
            FALLA:   siguiente = FALLA;
            default: siguiente = REPOSO;
        endcase
    end

    always_ff @(posedge Reloj) begin
        if (reset) begin
            estado     <= REPOSO;
            objetivo   <= '0;
            posicion   <= '0;
            pos_valida <= 1'b0;
            debajo     <= 1'b0;
            contador   <= '0;
        end else begin
            estado   <= siguiente;
            objetivo <= objetivo_sig;
            if (fin_hay) begin
                posicion   <= fin_idx;
                pos_valida <= 1'b1;
            end
            if (movimiento && fin_hay) debajo <= (estado == BAJANDO);
            // One counter serves both the stall timeout and the dead-time.
            if (siguiente != estado)
                contador <= '0;
            else if (movimiento && pos_cambia)
                contador <= '0;
            else if (movimiento || (estado == PAUSA))
                contador <= contador + CW'(1);
        end
    end

    assign persiana.subir      = (estado == SUBIENDO);
    assign persiana.bajar      = (estado == BAJANDO);
    assign persiana.posicion   = posicion;
    assign persiana.pos_valida = pos_valida;
    assign persiana.falla      = (estado == FALLA);
endmodule
